hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage core: next generation of the current forwarding unit, adding load-use stall, taken-branch flush and multi-cycle EX-op stall on top of operand forwarding. Sits beside the ID/EX/MEM pipeline registers and drives their hold, bubble and flush controls plus the EX operand forward muxes. Keeps its own shadow tag pipeline (EX, MEM, WB), so it needs only ID-stage fields and the MEM-stage branch outcome.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/fwd_match.sv | 23 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: per-stage shadow tag and forward-select codes.
// Tag fields are sized for the largest supported core; narrower configs zero-extend into them.
package hazard_pkg;

   localparam int RAW_MAX  = 8;
   localparam int NSRC_MAX = 4;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic                               valid;
      logic [RAW_MAX-1:0]                 rd;
      logic                               regwrite;
      logic                               memread;
      logic                               multicycle;
      logic [NSRC_MAX-1:0][RAW_MAX-1:0]   rs;
      logic [NSRC_MAX-1:0]                rs_used;
   } stage_tag_t;

   localparam stage_tag_t NOP_TAG = '0;

   function automatic logic writes_reg(input stage_tag_t t, input logic [RAW_MAX-1:0] r);
      return t.valid && t.regwrite && (t.rd == r);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Forward-source select for one EX operand against the MEM and WB shadow tags.
module fwd_match
   import hazard_pkg::*;
(
   input  logic [RAW_MAX-1:0] src,
   input  logic               src_used,
   input  stage_tag_t         mem_tag,
   input  stage_tag_t         wb_tag,
   output logic [1:0]         sel
);

   // The younger writer (MEM) always shadows the older one (WB).
   always_comb begin
      sel = FWD_RF;
      if (src_used && (src != '0)) begin
         if (writes_reg(mem_tag, src))
            sel = FWD_EXMEM;
         else if (writes_reg(wb_tag, src))
            sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, multi-cycle EX hold and
// taken-branch flush, driven from a private EX/MEM/WB shadow tag pipeline.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NSRC   = 2,
   parameter int RAW    = 5,
   parameter int MC_LAT = 4
) (
   input  logic                  cpuclk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [NSRC*RAW-1:0]   id_rs,
   input  logic [NSRC-1:0]       id_rs_used,
   input  logic [RAW-1:0]        id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  id_multicycle,
   input  logic                  mem_branch_taken,
   output logic                  stall_pc,
   output logic                  stall_ifid,
   output logic                  stall_idex,
   output logic                  bubble_idex,
   output logic                  bubble_exmem,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  flush_exmem,
   output logic [2*NSRC-1:0]     fwd_sel,
   output logic                  mc_busy
);

   localparam int                CNT_W   = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
   localparam logic [CNT_W-1:0]  MC_LOAD = CNT_W'(MC_LAT - 1);

   stage_tag_t        id_tag, ex_tag, mem_tag, wb_tag;
   logic [CNT_W-1:0]  mc_cnt;
   logic              lu_hit;

   always_comb begin
      id_tag            = NOP_TAG;
      id_tag.valid      = id_valid;
      id_tag.rd         = RAW_MAX'(id_rd);
      id_tag.regwrite   = id_regwrite;
      id_tag.memread    = id_memread;
      id_tag.multicycle = id_multicycle;
      for (int k = 0; k < NSRC; k++) begin
         id_tag.rs[k]      = RAW_MAX'(id_rs[k*RAW +: RAW]);
         id_tag.rs_used[k] = id_rs_used[k];
      end
   end

   always_comb begin
      lu_hit = 1'b0;
      if (id_valid && ex_tag.valid && ex_tag.memread && (ex_tag.rd != '0)) begin
         for (int k = 0; k < NSRC; k++)
            if (id_tag.rs_used[k] && (id_tag.rs[k] == ex_tag.rd))
               lu_hit = 1'b1;
      end
   end

   assign mc_busy = (mc_cnt != '0);

   // Flush outranks the multi-cycle hold, which in turn covers any load-use hazard.
   always_comb begin
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      stall_idex   = 1'b0;
      bubble_idex  = 1'b0;
      bubble_exmem = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      flush_exmem  = 1'b0;
      if (mem_branch_taken) begin
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
      end else if (mc_busy) begin
         stall_pc     = 1'b1;
         stall_ifid   = 1'b1;
         stall_idex   = 1'b1;
         bubble_exmem = 1'b1;
      end else if (lu_hit) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         bubble_idex = 1'b1;
      end
   end

   always_ff @(posedge cpuclk or negedge rst_n) begin
      if (!rst_n) begin
         ex_tag  <= NOP_TAG;
         mem_tag <= NOP_TAG;
         wb_tag  <= NOP_TAG;
      end else begin
         wb_tag  <= mem_tag;
         mem_tag <= (bubble_exmem || flush_exmem) ? NOP_TAG : ex_tag;
         if (!stall_idex)
            ex_tag <= (bubble_idex || flush_idex || !id_valid) ? NOP_TAG : id_tag;
      end
   end

   // Down-counter of remaining EX hold cycles; loads when a multi-cycle op actually enters EX.
   always_ff @(posedge cpuclk or negedge rst_n) begin
      if (!rst_n)
         mc_cnt <= '0;
      else if (mem_branch_taken)
         mc_cnt <= '0;
      else if (mc_busy)
         mc_cnt <= mc_cnt - CNT_W'(1);
      else if (!bubble_idex && id_valid && id_multicycle)
         mc_cnt <= MC_LOAD;
   end

   for (genvar k = 0; k < NSRC; k++) begin : g_fwd
      fwd_match u_fwd_match (
         .src      (ex_tag.rs[k]),
         .src_used (ex_tag.valid & ex_tag.rs_used[k]),
         .mem_tag  (mem_tag),
         .wb_tag   (wb_tag),
         .sel      (fwd_sel[2*k +: 2])
      );
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random instruction streams,
// checked every cycle against an instruction-level pipeline model.
module tb_hazard_ctrl;

   localparam int NSRC   = 2;
   localparam int RAW    = 5;
   localparam int MC_LAT = 4;

   logic                cpuclk = 1'b0;
   logic                rst_n;
   logic                id_valid;
   logic [NSRC*RAW-1:0] id_rs;
   logic [NSRC-1:0]     id_rs_used;
   logic [RAW-1:0]      id_rd;
   logic                id_regwrite, id_memread, id_multicycle, mem_branch_taken;
   logic                stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem;
   logic                flush_ifid, flush_idex, flush_exmem, mc_busy;
   logic [2*NSRC-1:0]   fwd_sel;
   logic [8:0]          dut_ctrl;

   always #5 cpuclk = ~cpuclk;

   hazard_ctrl #(.NSRC(NSRC), .RAW(RAW), .MC_LAT(MC_LAT)) dut (
      .cpuclk(cpuclk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_multicycle(id_multicycle),
      .mem_branch_taken(mem_branch_taken), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .stall_idex(stall_idex), .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
      .fwd_sel(fwd_sel), .mc_busy(mc_busy)
   );

   assign dut_ctrl = {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem,
                      flush_ifid, flush_idex, flush_exmem, mc_busy};

   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit mr;
      bit mc;
      int rs[NSRC];
      bit used[NSRC];
   } ins_t;

   // Instruction records in EX/MEM/WB; m_age counts cycles the EX instruction has spent in EX.
   ins_t       m_ex, m_mem, m_wb;
   int         m_age;
   bit         e_busy, e_lu, e_flush;
   logic [8:0] e_ctrl;
   logic [2*NSRC-1:0] e_fwd;
   int         total = 0;
   int         bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ins_t nop_ins();
      ins_t n;
      n.v = 0; n.rd = 0; n.rw = 0; n.mr = 0; n.mc = 0;
      for (int k = 0; k < NSRC; k++) begin
         n.rs[k] = 0;
         n.used[k] = 0;
      end
      return n;
   endfunction

   function automatic ins_t cur_id();
      ins_t n;
      n.v = id_valid; n.rd = int'(id_rd); n.rw = id_regwrite;
      n.mr = id_memread; n.mc = id_multicycle;
      for (int k = 0; k < NSRC; k++) begin
         n.rs[k]   = int'(id_rs[k*RAW +: RAW]);
         n.used[k] = id_rs_used[k];
      end
      return n;
   endfunction

   task automatic model_reset();
      m_ex = nop_ins(); m_mem = nop_ins(); m_wb = nop_ins(); m_age = 0;
   endtask

   task automatic model_eval();
      ins_t id_i;
      bit   lu;
      id_i    = cur_id();
      e_flush = mem_branch_taken;
      e_busy  = m_ex.v && m_ex.mc && (m_age < MC_LAT - 1);
      lu = 0;
      if (id_i.v && m_ex.v && m_ex.mr && m_ex.rd != 0)
         for (int k = 0; k < NSRC; k++)
            if (id_i.used[k] && id_i.rs[k] == m_ex.rd) lu = 1;
      e_lu   = lu && !e_busy && !e_flush;
      e_ctrl = {!e_flush && (e_busy || lu), !e_flush && (e_busy || lu), !e_flush && e_busy,
                e_lu, !e_flush && e_busy, e_flush, e_flush, e_flush, e_busy};
      e_fwd = '0;
      for (int k = 0; k < NSRC; k++)
         if (m_ex.v && m_ex.used[k] && m_ex.rs[k] != 0) begin
            if (m_mem.v && m_mem.rw && m_mem.rd == m_ex.rs[k])    e_fwd[2*k +: 2] = 2'b01;
            else if (m_wb.v && m_wb.rw && m_wb.rd == m_ex.rs[k])  e_fwd[2*k +: 2] = 2'b10;
         end
   endtask

   task automatic model_advance(input ins_t id_i);
      m_wb  = m_mem;
      m_mem = (e_flush || e_busy) ? nop_ins() : m_ex;
      if (e_busy && !e_flush) begin
         m_age++;
      end else begin
         m_ex  = (e_flush || e_lu || !id_i.v) ? nop_ins() : id_i;
         m_age = 0;
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
      check_val("ctrl", dut_ctrl, e_ctrl);
      check_val("fwd", fwd_sel, e_fwd);
   endtask

   task automatic advance();
      ins_t idc;
      idc = cur_id();
      @(posedge cpuclk);
      model_advance(idc);
      @(negedge cpuclk);
   endtask

   task automatic run_cycle();
      settle();
      advance();
   endtask

   task automatic set_id(input bit v, input int rd, input int rs0, input int rs1,
                         input bit [1:0] used, input bit rw, input bit mr, input bit mc);
      id_valid      = v;
      id_rd         = RAW'(rd);
      id_rs         = {RAW'(rs1), RAW'(rs0)};
      id_rs_used    = used;
      id_regwrite   = rw;
      id_memread    = mr;
      id_multicycle = mc;
   endtask

   int  busy_cnt, bub_cnt;
   bit  held;

   initial begin
      rst_n = 1'b0;
      mem_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0);
      model_reset();
      #12;
      check_val("rst_ctrl", dut_ctrl, 9'd0);
      check_val("rst_fwd", fwd_sel, 4'd0);
      @(negedge cpuclk);
      rst_n = 1'b1;

      // add x5 ; sub x6,x5,x5 ; or x9,x5
      set_id(1, 5, 1, 2, 2'b11, 1, 0, 0); run_cycle();
      set_id(1, 6, 5, 5, 2'b11, 1, 0, 0); run_cycle();
      set_id(1, 9, 5, 0, 2'b01, 1, 0, 0); settle();
      check_val("alu_fwd_exmem", fwd_sel, 4'b0101);
      advance();
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0); settle();
      check_val("alu_fwd_memwb", fwd_sel, 4'b0010);
      advance();

      // lw x7 ; add x8,x7,x1
      set_id(1, 7, 2, 0, 2'b01, 1, 1, 0); run_cycle();
      set_id(1, 8, 7, 1, 2'b11, 1, 0, 0); settle();
      check_val("lu_stall", dut_ctrl, 9'b110100000);
      advance();
      settle();
      check_val("lu_release", dut_ctrl, 9'd0);
      advance();
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0); settle();
      check_val("lu_fwd", fwd_sel, 4'b0010);
      advance();

      // multi-cycle op then an independent instruction held behind it
      set_id(1, 10, 1, 2, 2'b11, 1, 0, 1); run_cycle();
      set_id(1, 11, 12, 0, 2'b01, 1, 0, 0);
      busy_cnt = 0; bub_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         settle();
         if (mc_busy && stall_pc && stall_ifid && stall_idex) busy_cnt++;
         if (bubble_exmem) bub_cnt++;
         advance();
      end
      check_val("mc_busy_cycles", busy_cnt, MC_LAT - 1);
      check_val("mc_bubble_cycles", bub_cnt, MC_LAT - 1);

      // taken branch while a load-use is pending
      set_id(1, 7, 2, 0, 2'b01, 1, 1, 0); run_cycle();
      set_id(1, 8, 7, 0, 2'b01, 1, 0, 0); mem_branch_taken = 1'b1; settle();
      check_val("flush_over_lu", dut_ctrl, 9'b000001110);
      advance();
      mem_branch_taken = 1'b0; settle();
      check_val("flush_ex_killed", dut_ctrl, 9'd0);
      advance();

      // loads to x0, unused source slots
      set_id(1, 0, 2, 0, 2'b01, 1, 1, 0); run_cycle();
      set_id(1, 3, 0, 0, 2'b11, 1, 0, 0); settle();
      check_val("x0_no_stall", dut_ctrl, 9'd0);
      advance();
      set_id(1, 7, 2, 0, 2'b01, 1, 1, 0); run_cycle();
      set_id(1, 4, 7, 7, 2'b00, 1, 0, 0); settle();
      check_val("unused_no_stall", dut_ctrl, 9'd0);
      advance();
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0); settle();
      check_val("unused_fwd", fwd_sel, 4'd0);
      advance();

      // reset in the middle of a multi-cycle hold
      set_id(1, 13, 1, 0, 2'b01, 1, 0, 1); run_cycle();
      set_id(1, 14, 13, 0, 2'b01, 1, 0, 0); settle();
      check_val("mc_before_rst", mc_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_mid_ctrl", dut_ctrl, 9'd0);
      check_val("rst_mid_fwd", fwd_sel, 4'd0);
      model_reset();
      @(negedge cpuclk);
      rst_n = 1'b1;
      set_id(1, 15, 1, 2, 2'b11, 1, 0, 0); run_cycle();
      set_id(1, 16, 15, 0, 2'b01, 1, 0, 0); run_cycle();

      // random instruction stream; ID is held whenever the controller stalls it
      held = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!held)
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         mem_branch_taken = ($urandom_range(0, 15) == 0);
         run_cycle();
         held = e_ctrl[7];
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
